// File: rtl/wb_bram_burst_if.sv
// ============================================================================
// Module  : wb_bram_burst_if
// Brief   : Wishbone B4 bus bundle for wb_bram_burst (master/slave modports).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_bram_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 32
);
  logic [ADR_WIDTH-1:0]    adr;
  logic [DATA_WIDTH-1:0]   dat_ms;
  logic [DATA_WIDTH-1:0]   dat_sm;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_ms, sel, cyc, stb, we, cti, bte,
    input  dat_sm, ack, err
  );

  modport slave (
    input  adr, dat_ms, sel, cyc, stb, we, cti, bte,
    output dat_sm, ack, err
  );
endinterface

`default_nettype wire

// File: rtl/wb_bram_burst.sv
// ============================================================================
// Module  : wb_bram_burst
// Brief   : Wishbone B4 registered-feedback BlockRAM slave with pipelined
//           incrementing/wrapping burst reads. Optional out-of-range error
//           response is enabled by defining WB_BRAM_BURST_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  wb_bram_burst_if.slave  wb
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned BYTE_OFS  = $clog2(NUM_LANES);
  localparam int unsigned DEPTH     = 2 ** MEM_ADR_WIDTH;
  localparam int unsigned IDX_MSB   = MEM_ADR_WIDTH + BYTE_OFS - 1;

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [1:0]               state_q, state_d;
  logic [MEM_ADR_WIDTH-1:0] addr_q, addr_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    dat_sm_q;

  logic [MEM_ADR_WIDTH-1:0] w_idx;
  logic [MEM_ADR_WIDTH-1:0] w_nxt;
  logic [ADR_WIDTH-1:0]     w_unused_adr;
  logic w_req, w_rreq, w_wreq, w_wr, w_illegal, w_load;
  logic w_cti_inc, w_cti_eob, w_rd_beat, w_hit, w_burst_err;

  // Incrementing within the wrap window; bte=00 wraps at the top of memory.
  function automatic logic [MEM_ADR_WIDTH-1:0] next_idx(
    input logic [MEM_ADR_WIDTH-1:0] idx,
    input logic [1:0]               bte
  );
    logic [MEM_ADR_WIDTH-1:0] inc;
    logic [MEM_ADR_WIDTH-1:0] mask;
    inc = idx + MEM_ADR_WIDTH'(1);
    case (bte)
      2'b01:   mask = MEM_ADR_WIDTH'(3);
      2'b10:   mask = MEM_ADR_WIDTH'(7);
      2'b11:   mask = MEM_ADR_WIDTH'(15);
      default: mask = '1;
    endcase
    return (idx & ~mask) | (inc & mask);
  endfunction

  assign w_unused_adr = wb.adr;
  assign w_idx        = wb.adr[IDX_MSB:BYTE_OFS];
  assign w_nxt        = next_idx(addr_q, wb.bte);

`ifdef WB_BRAM_BURST_ERR_EN
  assign w_illegal = |wb.adr[ADR_WIDTH-1:IDX_MSB+1];
`else
  assign w_illegal = 1'b0;
`endif

  assign w_req       = wb.cyc & wb.stb;
  assign w_rreq      = w_req & ~wb.we;
  assign w_wreq      = w_req & wb.we;
  assign w_wr        = w_wreq & ~w_illegal;
  assign w_cti_inc   = (wb.cti == CTI_INC);
  assign w_cti_eob   = (wb.cti == CTI_EOB);
  assign w_rd_beat   = (state_q == S_RD) & w_rreq;
  assign w_hit       = (state_q == S_BURST) & w_rreq & (w_cti_inc | w_cti_eob)
                     & (w_idx == addr_q) & ~w_illegal;
  assign w_burst_err = (state_q == S_BURST) & w_rreq & w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // addr_q always names the word whose data sits (or is landing) in dat_sm_q.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    w_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_rreq) begin
          state_d = S_RD;
          addr_d  = w_idx;
          err_d   = w_illegal;
          w_load  = 1'b1;
        end
      end
      S_RD: begin
        state_d = S_IDLE;
        if (w_rd_beat && w_cti_inc && !err_q) begin
          state_d = S_BURST;
          addr_d  = w_nxt;
          w_load  = 1'b1;
        end
      end
      S_BURST: begin
        if (w_hit && w_cti_inc) begin
          addr_d = w_nxt;
          w_load = 1'b1;
        end else if (w_hit || w_burst_err) begin
          state_d = S_IDLE;
        end else if (w_rreq) begin
          state_d = S_RD;
          addr_d  = w_idx;
          err_d   = w_illegal;
          w_load  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!wb.cyc) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    wb.ack = (w_wreq & ~w_illegal) | (w_rd_beat & ~err_q) | w_hit;
    wb.err = (w_wreq & w_illegal) | (w_rd_beat & err_q) | w_burst_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_sm_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
      if (w_load) begin
        dat_sm_q <= mem_q[addr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wb.sel[i]) begin
          mem_q[w_idx][i*8 +: 8] <= wb.dat_ms[i*8 +: 8];
        end
      end
    end
  end

  assign wb.dat_sm = dat_sm_q;

endmodule

`default_nettype wire
